conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Sequencer for the convolution IP. It computes z[i] = sum over j of x[j]*y[i-j], for i = 0 .. size_x+size_y-2.
- Drives the read ports of memX and memY, both synchronous-read with 1-cycle latency.
- Accumulates products internally and writes each result to memZ.
- Sits between the host register interface (start/sizes/done) and the three memories; it is the only master on their address/enable lines during a run.

Parameters:
DATA_WIDTH, 8, width of memX/memY words
ADDR_WIDTH, 3, memX/memY address width; sizes range 0..2^ADDR_WIDTH-1
Z_WIDTH, 16, width of the word written to memZ
ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, internal accumulator width (unsigned)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE only
size_x  in  ADDR_WIDTH  number of valid memX entries; latched on start
size_y  in  ADDR_WIDTH  number of valid memY entries; latched on start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
x_addr  out  ADDR_WIDTH  memX address
x_re  out  1  memX read enable
x_data  in  DATA_WIDTH  memX readData
y_addr  out  ADDR_WIDTH  memY address
y_re  out  1  memY read enable
y_data  in  DATA_WIDTH  memY readData
z_addr  out  ADDR_WIDTH+1  memZ address
z_we  out  1  memZ write enable
z_data  out  Z_WIDTH  memZ write data

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; acc, i, j and latched sizes clear to 0.
  - All outputs are 0: busy, done, x_re, y_re, z_we, all addresses and z_data.
  - A run interrupted by reset issues no further z_we.
- States: IDLE, READ, MAC, WRITE, DONE.
- IDLE: if start=1 at a clock edge:
  - Latch size_x and size_y.
  - If either size is 0, go to DONE with no memory accesses.
  - Otherwise set i=0, j=0, acc=0 and go to READ.
  - start while busy is ignored.
- READ (1 cycle): x_re=y_re=1, x_addr=j, y_addr=i-j; go to MAC.
- MAC (1 cycle): acc <= acc + x_data*y_data, an exact unsigned product. If j==jmax go to WRITE, else j++ and go to READ.
  - jmin(i) = max(0, i-(size_y-1)); jmax(i) = min(i, size_x-1).
- WRITE (1 cycle):
  - z_we=1, z_addr=i, z_data=acc reduced to Z_WIDTH (see Optional Feature).
  - If i==size_x+size_y-2, go to DONE.
  - Else i++, acc=0, j=jmin(i+1), and go to READ.
- DONE (1 cycle): done=1, busy=1; go to IDLE.
- Outside the states named above, x_re, y_re and z_we are 0. Addresses hold their last value and are don't-care when the enables are low.
- Timing: with start sampled at edge k, the first READ cycle follows edge k. There are exactly 2*sx*sy + (sx+sy-1) cycles in READ/MAC/WRITE, and done is high in the next cycle.
- Zero-size run: done is high in the cycle after edge k; busy is high for that cycle only.
- Results are written in ascending z_addr order, each address exactly once.
- Sizes larger than the physical memory depth (memY holds 5 words) are a caller error and are not checked.
- Arithmetic is unsigned throughout; ACC_WIDTH never overflows for legal sizes.

Optional Feature:
Macro CONV_SEQ_SATURATE_EN.
- Defined: if acc > 2^Z_WIDTH-1, z_data = 2^Z_WIDTH-1; otherwise z_data = acc.
- Undefined: z_data = acc[Z_WIDTH-1:0] (modulo truncation).
- Timing is identical in both builds.

Decomposition:
- Package conv_pkg: state enum (IDLE/READ/MAC/WRITE/DONE), default width constants, and a function computing ACC_WIDTH from DATA_WIDTH and ADDR_WIDTH.
- Sub-module conv_mac holds the accumulator:
  - Inputs: clear, accumulate enable, two operands.
  - Output: acc, plus the Z_WIDTH result, which contains the saturation/truncation logic under CONV_SEQ_SATURATE_EN.
  - The FSM, index counters and jmin/jmax logic stay in conv_seq_ctrl.

Test Plan:
- Basic run: x={1,2,3}, y={1,1}, sizes 3/2, start pulse -> memZ={1,3,5,3} at addr 0..3, exactly 4 z_we pulses, done high exactly 17 cycles after the start edge, busy low afterwards.
- Full memY: x={2}, y={1,2,3,4,5}, sizes 1/5 -> z={2,4,6,8,10}, 5 cycles in READ/MAC/WRITE pairs+writes as per the formula (2*5+5=15), y_addr sequence 0..4.
- Zero size: size_x=0, size_y=3, start -> no x_re/y_re/z_we, done the cycle after start, busy for 1 cycle only.
- Overflow: x={255,255}, y={255,255}, sizes 2/2 -> z[1]: 130050 accumulated.
  - With CONV_SEQ_SATURATE_EN: z[1]=65535.
  - Without: z[1]=64514.
  - z[0]=65025 in both builds.
- Reset mid-run: assert rst_n=0 during the second WRITE of the basic run -> all outputs 0 immediately (asynchronous), no further z_we. After release, a new start reproduces the full basic result.
- Start while busy: pulse start with new sizes mid-run -> ignored, and the original run completes unchanged.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared constants, FSM state encoding and accumulator sizing for the convolution sequencer.
package conv_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 3;
   localparam int unsigned DEF_Z_WIDTH    = 16;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StRead  = 3'd1;
   localparam state_t StMac   = 3'd2;
   localparam state_t StWrite = 3'd3;
   localparam state_t StDone  = 3'd4;

   // Holds up to 2^aw products of two dw-bit words without overflow.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned aw);
      return 2 * dw + aw;
   endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Memory-side bus of the convolution sequencer: memX/memY read ports and memZ write port.
interface conv_seq_ctrl_if
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned Z_WIDTH    = DEF_Z_WIDTH
);

   logic [ADDR_WIDTH-1:0] x_addr;
   logic                  x_re;
   logic [DATA_WIDTH-1:0] x_data;
   logic [ADDR_WIDTH-1:0] y_addr;
   logic                  y_re;
   logic [DATA_WIDTH-1:0] y_data;
   logic [ADDR_WIDTH:0]   z_addr;
   logic                  z_we;
   logic [Z_WIDTH-1:0]    z_data;

   modport master (
      output x_addr, x_re, y_addr, y_re, z_addr, z_we, z_data,
      input  x_data, y_data
   );

   modport slave (
      input  x_addr, x_re, y_addr, y_re, z_addr, z_we, z_data,
      output x_data, y_data
   );

endinterface

// File: rtl/conv_seq_ctrl_mac.sv
// Unsigned multiply-accumulator with Z_WIDTH result reduction.
// CONV_SEQ_SATURATE_EN selects saturation instead of modulo truncation.
module conv_mac
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_ADDR_WIDTH),
   parameter int unsigned Z_WIDTH    = DEF_Z_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic [Z_WIDTH-1:0]    z
);

   logic [2*DATA_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]    acc_q;

   assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
      end else if (acc_en) begin
         acc_q <= acc_q + ACC_WIDTH'(prod);
      end
   end

   assign acc = acc_q;

`ifdef CONV_SEQ_SATURATE_EN
   always_comb begin
      z = Z_WIDTH'(acc_q);
      if ((acc_q >> Z_WIDTH) != '0) begin
         z = '1;
      end
   end
`else
   assign z = Z_WIDTH'(acc_q);
`endif

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks z[i] = sum x[j]*y[i-j], reading memX/memY and writing memZ.
// Result reduction to Z_WIDTH is selected by CONV_SEQ_SATURATE_EN (see conv_mac).
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned Z_WIDTH    = DEF_Z_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] size_x,
   input  logic [ADDR_WIDTH-1:0] size_y,
   output logic                  busy,
   output logic                  done,
   conv_seq_ctrl_if.master       mem
);

   localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_WIDTH);
   localparam int unsigned IW        = ADDR_WIDTH + 1;

   state_t                state_q, state_d;
   logic [IW-1:0]         i_q, i_d;
   logic [ADDR_WIDTH-1:0] j_q, j_d, sx_q, sx_d, sy_q, sy_d;
   logic [IW-1:0]         sx_ext, sy_ext, i_inc, i_last, jmax, jmin_full;
   logic [ADDR_WIDTH-1:0] jmin_inc;
   logic                  j_at_max, i_at_last, acc_clear, acc_en;
   logic                  unused_jbit, unused_ybit;
   logic [ACC_WIDTH-1:0]  acc_unused;

   assign sx_ext    = IW'(sx_q);
   assign sy_ext    = IW'(sy_q);
   assign i_inc     = i_q + IW'(1);
   assign i_last    = sx_ext + sy_ext - IW'(2);
   assign jmax      = (i_q < sx_ext - IW'(1)) ? i_q : sx_ext - IW'(1);
   // jmin of the next output index; always < size_x, so it fits in j.
   assign jmin_full = (i_inc >= sy_ext - IW'(1)) ? i_inc - (sy_ext - IW'(1)) : '0;
   assign {unused_jbit, jmin_inc} = jmin_full;
   assign j_at_max  = (IW'(j_q) == jmax);
   assign i_at_last = (i_q == i_last);

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      acc_clear = 1'b0;
      acc_en    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               sx_d      = size_x;
               sy_d      = size_y;
               i_d       = '0;
               j_d       = '0;
               acc_clear = 1'b1;
               state_d   = (size_x == '0 || size_y == '0) ? StDone : StRead;
            end
         end
         StRead:  state_d = StMac;
         StMac: begin
            acc_en = 1'b1;
            if (j_at_max) begin
               state_d = StWrite;
            end else begin
               j_d     = j_q + ADDR_WIDTH'(1);
               state_d = StRead;
            end
         end
         StWrite: begin
            if (i_at_last) begin
               state_d = StDone;
            end else begin
               i_d       = i_inc;
               j_d       = jmin_inc;
               acc_clear = 1'b1;
               state_d   = StRead;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign mem.x_re   = (state_q == StRead);
   assign mem.y_re   = (state_q == StRead);
   assign mem.z_we   = (state_q == StWrite);
   assign mem.x_addr = j_q;
   assign mem.z_addr = i_q;
   assign {unused_ybit, mem.y_addr} = i_q - IW'(j_q);

   conv_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .Z_WIDTH    (Z_WIDTH)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (acc_clear),
      .acc_en (acc_en),
      .a      (mem.x_data),
      .b      (mem.y_data),
      .acc    (acc_unused),
      .z      (mem.z_data)
   );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl with behavioural memories and a convolution reference model.
module tb_conv_seq_ctrl;
   import conv_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int ZW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] size_x = '0;
   logic [AW-1:0] size_y = '0;
   logic          busy, done;

   conv_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Z_WIDTH(ZW)) mif ();

   conv_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Z_WIDTH(ZW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .size_x (size_x),
      .size_y (size_y),
      .busy   (busy),
      .done   (done),
      .mem    (mif)
   );

   always #5 clk = ~clk;

   int unsigned xmem [8];
   int unsigned ymem [8];
   int          vectors = 0;
   int          miscompares = 0;

   // Synchronous-read memories, one cycle latency.
   always @(posedge clk) begin
      if (mif.x_re) mif.x_data <= DW'(xmem[mif.x_addr]);
      if (mif.y_re) mif.y_data <= DW'(ymem[mif.y_addr]);
   end

   int zq_addr[$];
   int zq_data[$];
   int yseq[$];
   int nx, ny, nbusy;

   always @(negedge clk) begin
      if (mif.z_we) begin
         zq_addr.push_back(int'(mif.z_addr));
         zq_data.push_back(int'(mif.z_data));
      end
      if (mif.x_re) nx++;
      if (mif.y_re) begin
         ny++;
         yseq.push_back(int'(mif.y_addr));
      end
      if (busy) nbusy++;
   end

   function automatic longint ref_acc(input int i, input int sx, input int sy);
      longint s = 0;
      for (int j = 0; j < sx; j++)
         if (i - j >= 0 && i - j < sy) s += longint'(xmem[j]) * longint'(ymem[i - j]);
      return s;
   endfunction

   function automatic int ref_z(input longint a);
`ifdef CONV_SEQ_SATURATE_EN
      return (a > 65535) ? 65535 : int'(a);
`else
      return int'(a % 65536);
`endif
   endfunction

   int lat;
   bit tmo;

   task automatic do_run(input int sx, input int sy, input int poke_at);
      zq_addr.delete(); zq_data.delete(); yseq.delete();
      nx = 0; ny = 0; nbusy = 0;
      @(negedge clk);
      size_x = AW'(sx); size_y = AW'(sy); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 400) begin
         @(posedge clk); #1 lat++;
         if (lat == poke_at) begin start = 1'b1; size_x = 1; size_y = 1; end
         if (lat == poke_at + 2) start = 1'b0;
      end
      tmo = !done;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, mif.x_re, mif.y_re, mif.z_we} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mif.x_re, mif.y_re, mif.z_we});
      end
      vectors++;
      if ({mif.x_addr, mif.y_addr, mif.z_addr, mif.z_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: xa=%0d ya=%0d za=%0d zd=%0d want all 0",
                  mif.x_addr, mif.y_addr, mif.z_addr, mif.z_data);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic load_basic();
      foreach (xmem[k]) begin xmem[k] = 0; ymem[k] = 0; end
      xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
      ymem[0] = 1; ymem[1] = 1;
   endtask

   task automatic test_basic(input string tag, input int poke_at);
      int exp_z[4] = '{1, 3, 5, 3};
      load_basic();
      do_run(3, 2, poke_at);
      vectors++;
      if (tmo || lat != 16) begin
         miscompares++;
         $display("FAIL %s_latency: got %0d (timeout %0d) want 16", tag, lat, tmo);
      end
      vectors++;
      if (zq_addr.size() != 4) begin
         miscompares++;
         $display("FAIL %s_zcount: got %0d want 4", tag, zq_addr.size());
      end
      for (int k = 0; k < 4 && k < zq_addr.size(); k++) begin
         vectors++;
         if (zq_addr[k] != k || zq_data[k] != exp_z[k]) begin
            miscompares++;
            $display("FAIL %s_z%0d: got addr %0d data %0d want addr %0d data %0d",
                     tag, k, zq_addr[k], zq_data[k], k, exp_z[k]);
         end
      end
      vectors++;
      if (nbusy != 17 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_busy: got %0d busy cycles, busy=%b done=%b after; want 17,0,0",
                  tag, nbusy, busy, done);
      end
   endtask

   task automatic test_full_y();
      int exp_z[5] = '{2, 4, 6, 8, 10};
      foreach (xmem[k]) begin xmem[k] = 0; ymem[k] = 0; end
      xmem[0] = 2;
      for (int k = 0; k < 5; k++) ymem[k] = k + 1;
      do_run(1, 5, -10);
      vectors++;
      if (tmo || lat != 15) begin
         miscompares++;
         $display("FAIL fully_latency: got %0d want 15", lat);
      end
      vectors++;
      if (zq_addr.size() != 5 || yseq.size() != 5) begin
         miscompares++;
         $display("FAIL fully_count: got %0d writes %0d reads want 5 5", zq_addr.size(), yseq.size());
      end
      for (int k = 0; k < 5 && k < zq_addr.size() && k < yseq.size(); k++) begin
         vectors++;
         if (zq_addr[k] != k || zq_data[k] != exp_z[k] || yseq[k] != k) begin
            miscompares++;
            $display("FAIL fully_z%0d: got addr %0d data %0d yaddr %0d want %0d %0d %0d",
                     k, zq_addr[k], zq_data[k], yseq[k], k, exp_z[k], k);
         end
      end
   endtask

   task automatic test_zero_size();
      do_run(0, 3, -10);
      vectors++;
      if (tmo || lat != 0) begin
         miscompares++;
         $display("FAIL zero_latency: got %0d want 0", lat);
      end
      vectors++;
      if (nx != 0 || ny != 0 || zq_addr.size() != 0 || nbusy != 1) begin
         miscompares++;
         $display("FAIL zero_access: got xre %0d yre %0d zwe %0d busy %0d want 0 0 0 1",
                  nx, ny, zq_addr.size(), nbusy);
      end
   endtask

   task automatic test_overflow();
`ifdef CONV_SEQ_SATURATE_EN
      int exp_z[3] = '{65025, 65535, 65025};
`else
      int exp_z[3] = '{65025, 64514, 65025};
`endif
      foreach (xmem[k]) begin xmem[k] = 0; ymem[k] = 0; end
      xmem[0] = 255; xmem[1] = 255; ymem[0] = 255; ymem[1] = 255;
      do_run(2, 2, -10);
      vectors++;
      if (tmo || zq_addr.size() != 3 || lat != 11) begin
         miscompares++;
         $display("FAIL ovf_shape: got %0d writes lat %0d want 3 11", zq_addr.size(), lat);
      end
      for (int k = 0; k < 3 && k < zq_addr.size(); k++) begin
         vectors++;
         if (zq_data[k] != exp_z[k]) begin
            miscompares++;
            $display("FAIL ovf_z%0d: got %0d want %0d", k, zq_data[k], exp_z[k]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      int cnt = 0;
      int guard = 0;
      load_basic();
      zq_addr.delete(); zq_data.delete();
      @(negedge clk);
      size_x = 3; size_y = 2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (cnt < 2 && guard < 100) begin
         @(posedge clk); #1 guard++;
         if (mif.z_we) cnt++;
      end
      vectors++;
      if (cnt != 2) begin
         miscompares++;
         $display("FAIL rstmid_reach: got %0d writes want 2", cnt);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, mif.x_re, mif.y_re, mif.z_we, mif.x_addr, mif.y_addr,
           mif.z_addr, mif.z_data} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: busy=%b we=%b za=%0d zd=%0d want all 0",
                  busy, mif.z_we, mif.z_addr, mif.z_data);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (zq_addr.size() != 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_nowrite: got %0d writes busy %b want 1 0", zq_addr.size(), busy);
      end
      test_basic("after_rst", -10);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int sx = int'($urandom_range(1, 7));
         int sy = int'($urandom_range(1, 5));
         int nz = sx + sy - 1;
         for (int k = 0; k < 8; k++) begin
            xmem[k] = (r < 2) ? $urandom_range(200, 255) : $urandom_range(0, 255);
            ymem[k] = (r < 2) ? $urandom_range(200, 255) : $urandom_range(0, 255);
         end
         do_run(sx, sy, -10);
         vectors++;
         if (tmo || lat != 2 * sx * sy + nz || zq_addr.size() != nz || nx != sx * sy) begin
            miscompares++;
            $display("FAIL rand%0d_shape: sx %0d sy %0d got lat %0d writes %0d reads %0d want %0d %0d %0d",
                     r, sx, sy, lat, zq_addr.size(), nx, 2 * sx * sy + nz, nz, sx * sy);
         end
         for (int k = 0; k < nz && k < zq_addr.size(); k++) begin
            int e = ref_z(ref_acc(k, sx, sy));
            vectors++;
            if (zq_addr[k] != k || zq_data[k] != e) begin
               miscompares++;
               $display("FAIL rand%0d_z%0d: got addr %0d data %0d want addr %0d data %0d",
                        r, k, zq_addr[k], zq_data[k], k, e);
            end
         end
      end
   endtask

   initial begin
      mif.x_data = '0;
      mif.y_data = '0;
      foreach (xmem[k]) begin xmem[k] = 0; ymem[k] = 0; end
      test_reset();
      test_basic("basic", -10);
      test_full_y();
      test_zero_size();
      test_overflow();
      test_reset_midrun();
      test_basic("start_busy", 5);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
